// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared stopwatch types and constants
// Shared with the display driver: controller state encoding, BCD digit width,
// field select codes and per-digit blank masks (bit3 = min_tens).
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_ADJUST = 2'd3
    } sw_state_t;

    localparam logic SEL_SEC = 1'b0;
    localparam logic SEL_MIN = 1'b1;

    localparam logic [3:0] BLANK_NONE = 4'b0000;
    localparam logic [3:0] BLANK_SEC  = 4'b0011;
    localparam logic [3:0] BLANK_MIN  = 4'b1100;

endpackage

// File: rtl/stopwatch_ctrl_bcd_field_counter.sv
// rtl/stopwatch_ctrl_bcd_field_counter.sv - two-digit BCD field counter
// Ports: clk, rst (async active-low), inc (count enable), clr (sync clear,
//        wins over inc), value {tens,ones}, carry_out (inc while at MAX).
// Parameter MAX: terminal decimal value; the field wraps to 00 after it.
module bcd_field_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    input  logic                   clr,
    output logic [2*DIGIT_W-1:0]   value,
    output logic                   carry_out
);

    localparam logic [DIGIT_W-1:0] TENS_MAX = DIGIT_W'(MAX / 10);
    localparam logic [DIGIT_W-1:0] ONES_MAX = DIGIT_W'(MAX % 10);

    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
    logic               at_max;

    assign at_max    = (tens == TENS_MAX) && (ones == ONES_MAX);
    assign carry_out = inc && at_max && !clr;
    assign value     = {tens, ones};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens <= '0;
            ones <= '0;
        end else if (clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (at_max) begin
                tens <= '0;
                ones <= '0;
            end else if (ones == DIGIT_W'(9)) begin
                ones <= '0;
                tens <= tens + DIGIT_W'(1);
            end else begin
                ones <= ones + DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - MM:SS stopwatch sequencing controller
// Ports: clk, rst (async active-low); tick_1hz/tick_adj/tick_blink divider
//        enables; btn_reset/btn_pause debounced levels; adj/sel switches;
//        digits {min_tens,min_ones,sec_tens,sec_ones}; running (registered
//        state==RUN); blank_mask (bit3 = min_tens).
// Optional: STOPWATCH_BLINK_EN adds the ADJUST blink phase; otherwise
//        blank_mask is constant zero and tick_blink is ignored.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic                  tick_adj,
    input  logic                  tick_blink,
    input  logic                  btn_reset,
    input  logic                  btn_pause,
    input  logic                  adj,
    input  logic                  sel,
    output logic [4*DIGIT_W-1:0]  digits,
    output logic                  running,
    output logic [3:0]            blank_mask
);

    sw_state_t state, state_nxt;
    logic      btn_reset_q, btn_pause_q;
    logic      reset_ev, pause_ev;
    logic      clr_cnt, run_inc, adj_inc;
    logic      sec_inc, min_inc, sec_carry, min_carry;
    logic      unused_carry;

    // One registered stage per button; a held level produces a single event.
    assign reset_ev = btn_reset && !btn_reset_q;
    assign pause_ev = btn_pause && !btn_pause_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            btn_reset_q <= 1'b0;
            btn_pause_q <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_nxt;
            btn_reset_q <= btn_reset;
            btn_pause_q <= btn_pause;
            running     <= (state == ST_RUN);
        end
    end

    // adj outranks both buttons; reset_ev outranks pause_ev. A tick in RUN is
    // still counted on the cycle the state leaves RUN, unless reset clears it.
    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
        run_inc   = 1'b0;
        adj_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (adj)           state_nxt = ST_ADJUST;
                else if (pause_ev) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                run_inc = tick_1hz;
                if (adj) begin
                    state_nxt = ST_ADJUST;
                end else if (reset_ev) begin
                    state_nxt = ST_IDLE;
                    clr_cnt   = 1'b1;
                    run_inc   = 1'b0;
                end else if (pause_ev) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (adj) begin
                    state_nxt = ST_ADJUST;
                end else if (reset_ev) begin
                    state_nxt = ST_IDLE;
                    clr_cnt   = 1'b1;
                end else if (pause_ev) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_ADJUST: begin
                if (!adj)          state_nxt = ST_PAUSE;
                else if (reset_ev) clr_cnt   = 1'b1;
                else               adj_inc   = tick_adj;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Adjust ticks bump only the selected field; the seconds carry reaches
    // the minutes only while running.
    assign sec_inc = run_inc || (adj_inc && (sel == SEL_SEC));
    assign min_inc = (run_inc && sec_carry) || (adj_inc && (sel == SEL_MIN));

    bcd_field_counter #(.MAX(SEC_MAX)) u_sec (
        .clk       (clk),
        .rst       (rst),
        .inc       (sec_inc),
        .clr       (clr_cnt),
        .value     (digits[2*DIGIT_W-1:0]),
        .carry_out (sec_carry)
    );

    bcd_field_counter #(.MAX(MIN_MAX)) u_min (
        .clk       (clk),
        .rst       (rst),
        .inc       (min_inc),
        .clr       (clr_cnt),
        .value     (digits[4*DIGIT_W-1:2*DIGIT_W]),
        .carry_out (min_carry)
    );

    // The minutes carry wraps 59:59 to 00:00 with nothing above it.
    assign unused_carry = min_carry;

`ifdef STOPWATCH_BLINK_EN
    logic blink_phase;

    // Cleared by looking at the next state so the phase is never 1 outside ADJUST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        blink_phase <= 1'b0;
        else if (state_nxt != ST_ADJUST) blink_phase <= 1'b0;
        else if ((state == ST_ADJUST) && tick_blink)
                                         blink_phase <= !blink_phase;
    end

    assign blank_mask = !blink_phase       ? BLANK_NONE :
                        (sel == SEL_MIN)   ? BLANK_MIN  : BLANK_SEC;
`else
    logic unused_blink;
    assign unused_blink = tick_blink;
    assign blank_mask   = BLANK_NONE;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_1hz = 1'b0, tick_adj = 1'b0, tick_blink = 1'b0;
    logic        btn_reset = 1'b0, btn_pause = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [15:0] digits;
    logic        running;
    logic [3:0]  blank_mask;

    stopwatch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .tick_adj   (tick_adj),
        .tick_blink (tick_blink),
        .btn_reset  (btn_reset),
        .btn_pause  (btn_pause),
        .adj        (adj),
        .sel        (sel),
        .digits     (digits),
        .running    (running),
        .blank_mask (blank_mask)
    );

    always #5 clk = ~clk;

`ifdef STOPWATCH_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ADJ = 3;

    typedef struct {
        logic [15:0] d;
        logic        r;
        logic [3:0]  b;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    int m_st = M_IDLE;
    int m_secs = 0;
    bit m_pbr = 0, m_pbp = 0, m_run = 0, m_phase = 0;

    bit cur_br = 0, cur_bp = 0, cur_adj = 0, cur_sel = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_digits(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Behavioural model: count kept as total seconds, fields derived by arithmetic.
    task automatic model_step(input bit br, bp, a, s, t1, ta, tb);
        bit   rev, pev;
        int   nst, mm, ss;
        exp_t e;
        rev = br && !m_pbr;
        pev = bp && !m_pbp;
        nst = m_st;
        case (m_st)
            M_IDLE: begin
                if (a) nst = M_ADJ;
                else if (pev) nst = M_RUN;
            end
            M_RUN: begin
                if (!a && rev) m_secs = 0;
                else if (t1) m_secs = (m_secs + 1) % 3600;
                if (a) nst = M_ADJ;
                else if (rev) nst = M_IDLE;
                else if (pev) nst = M_PAUSE;
            end
            M_PAUSE: begin
                if (a) nst = M_ADJ;
                else if (rev) begin nst = M_IDLE; m_secs = 0; end
                else if (pev) nst = M_RUN;
            end
            default: begin
                if (!a) nst = M_PAUSE;
                else if (rev) m_secs = 0;
                else if (ta) begin
                    mm = m_secs / 60;
                    ss = m_secs % 60;
                    if (s) mm = (mm + 1) % 60;
                    else   ss = (ss + 1) % 60;
                    m_secs = mm * 60 + ss;
                end
            end
        endcase
        if (BLINK) begin
            if (nst != M_ADJ) m_phase = 0;
            else if (m_st == M_ADJ && tb) m_phase = !m_phase;
        end
        m_run = (m_st == M_RUN);
        m_st  = nst;
        m_pbr = br;
        m_pbp = bp;
        e.d = to_digits(m_secs);
        e.r = m_run;
        e.b = !m_phase ? 4'b0000 : (s ? 4'b1100 : 4'b0011);
        q.push_back(e);
    endtask

    task automatic step(input bit t1, ta, tb);
        @(negedge clk);
        rst        = 1'b1;
        btn_reset  = cur_br;
        btn_pause  = cur_bp;
        adj        = cur_adj;
        sel        = cur_sel;
        tick_1hz   = t1;
        tick_adj   = ta;
        tick_blink = tb;
        model_step(cur_br, cur_bp, cur_adj, cur_sel, t1, ta, tb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic press_pause();
        cur_bp = 1; step(0, 0, 0);
        cur_bp = 0; step(0, 0, 0);
    endtask

    task automatic press_reset();
        cur_br = 1; step(0, 0, 0);
        cur_br = 0; step(0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset();
        exp_t e;
        @(negedge clk);
        cur_br = 0; cur_bp = 0;
        btn_reset = 0; btn_pause = 0;
        tick_1hz = 0; tick_adj = 0; tick_blink = 0;
        #2 rst = 1'b0;
        #1;
        chk("async_digits", digits, 0);
        chk("async_running", running, 0);
        chk("async_blank", blank_mask, 0);
        m_st = M_IDLE; m_secs = 0; m_pbr = 0; m_pbp = 0; m_run = 0; m_phase = 0;
        e.d = 16'h0000; e.r = 1'b0; e.b = 4'b0000;
        q.push_back(e);
    endtask

    // Monitor: every clock edge that had stimulus behind it yields one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_digits", digits, e.d);
                chk("sb_running", running, e.r);
                chk("sb_blank", blank_mask, e.b);
            end
        end
    end

    initial begin
        int rises;
        bit prev_run;
        #1;
        chk("rst_digits", digits, 0);
        chk("rst_running", running, 0);
        chk("rst_blank", blank_mask, 0);

        // 65 seconds of counting
        idle(2);
        press_pause();
        for (int i = 0; i < 65; i++) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        idle(2);
        chk("t1_digits", digits, 16'h0105);
        chk("t1_running", running, 1);

        // adjust up to 59:59, resume, wrap to 00:00
        cur_adj = 1; cur_sel = 0; step(0, 0, 0);
        for (int i = 0; i < 54; i++) step(0, 1, 0);
        cur_sel = 1;
        for (int i = 0; i < 58; i++) step(0, 1, 0);
        cur_adj = 0; step(0, 0, 0);
        press_pause();
        idle(2);
        chk("t2_pre", digits, 16'h5959);
        step(1, 0, 0);
        idle(2);
        chk("t2_wrap", digits, 16'h0000);
        chk("t2_running", running, 1);

        // pause in the same cycle as a tick at 00:07
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        cur_bp = 1; step(1, 0, 0);
        cur_bp = 0; step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        idle(2);
        chk("t3_digits", digits, 16'h0008);
        chk("t3_running", running, 0);

        // clear, then 62 adjust ticks on seconds wrap to 00:02
        press_reset();
        cur_adj = 1; cur_sel = 0; step(0, 0, 0);
        for (int i = 0; i < 62; i++) step(0, 1, 0);
        idle(1);
        chk("t4_digits", digits, 16'h0002);
        cur_adj = 0; step(1, 0, 0);
        step(1, 0, 0);
        idle(2);
        chk("t4_paused", digits, 16'h0002);
        chk("t4_running", running, 0);
        press_pause();
        step(1, 0, 0);
        idle(2);
        chk("t4_resume", digits, 16'h0003);

        // held pause button gives exactly one IDLE->RUN transition
        press_reset();
        idle(3);
        rises = 0;
        prev_run = running;
        cur_bp = 1;
        for (int i = 0; i < 1000; i++) begin
            step(0, 0, 0);
            if (running && !prev_run) rises++;
            prev_run = running;
        end
        cur_bp = 0;
        idle(2);
        if (running && !prev_run) rises++;
        chk("t5_one_run", rises, 1);

        // blink phase in ADJUST on the minutes field
        cur_adj = 1; cur_sel = 1; step(0, 0, 0);
        step(0, 0, 1);
        idle(1);
        chk("t6_blink_on", blank_mask, BLINK ? 4'b1100 : 4'b0000);
        step(0, 0, 1);
        idle(1);
        chk("t6_blink_off", blank_mask, 0);
        cur_adj = 0; idle(2);

        // mid-run asynchronous reset
        press_pause();
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        async_reset();
        idle(2);
        chk("ar_digits", digits, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
                continue;
            end
            if ($urandom_range(0, 5) == 0)  cur_bp  = !cur_bp;
            if ($urandom_range(0, 11) == 0) cur_br  = !cur_br;
            if ($urandom_range(0, 59) == 0) cur_adj = !cur_adj;
            if ($urandom_range(0, 7) == 0)  cur_sel = !cur_sel;
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0));
        end
        cur_br = 0; cur_bp = 0;
        idle(2);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        chk("sb_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
